bram_scrub_ctrl: RTL and testbench

- Controller that sequences one 2048x36 simple-dual-port block RAM (1-cycle registered read, read-first).
- Runs fill, verify and fill+verify sweeps across the whole array for memory re-initialisation experiments.
- Shares the RAM with one user port; the user has priority, with a bounded anti-starvation slot for the engine.
- Sits between test logic and the BRAM and owns the RAM's address, data and write-enable pins.

---
 rtl/bram_scrub_ctrl_pkg.sv | 29 ++
 rtl/bram_scrub_ctrl_if.sv | 27 ++
 rtl/scrub_bram.sv | 32 +++
 rtl/bram_scrub_ctrl.sv | 175 +++++++++++++++++
 tb/tb_bram_scrub_ctrl.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bram_scrub_ctrl_pkg.sv
// Shared types and default geometry for the BRAM scrub controller slice.
package bram_ctrl_pkg;

  localparam int WID_DEF         = 36;
  localparam int DEPTH_DEF       = 2048;
  localparam int AW_DEF          = $clog2(DEPTH_DEF);
  localparam int STALL_LIMIT_DEF = 4;

  // Sweep selection as presented on the mode pins; code 3 is reserved.
  typedef enum logic [1:0] {
    MODE_VERIFY      = 2'd0,
    MODE_FILL        = 2'd1,
    MODE_FILL_VERIFY = 2'd2
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_VERIFY,
    S_DRAIN,
    S_DONE
  } state_e;

  // True when the requested sweep begins with a fill phase.
  function automatic logic mode_fills(input logic [1:0] m);
    return (m == MODE_FILL) || (m == MODE_FILL_VERIFY);
  endfunction

endpackage

// File: rtl/bram_scrub_ctrl_if.sv
// User access port into the scrub controller: request/grant plus read return.
interface bram_scrub_ctrl_if #(
  parameter int WID = bram_ctrl_pkg::WID_DEF,
  parameter int AW  = bram_ctrl_pkg::AW_DEF
);

  logic           usr_req;
  logic           usr_we;
  logic [AW-1:0]  usr_addr;
  logic [WID-1:0] usr_wdata;
  logic           usr_gnt;
  logic           usr_rvalid;
  logic [WID-1:0] usr_rdata;

  // Test logic issuing accesses.
  modport master (
    output usr_req, usr_we, usr_addr, usr_wdata,
    input  usr_gnt, usr_rvalid, usr_rdata
  );

  // Controller arbitrating the RAM.
  modport slave (
    input  usr_req, usr_we, usr_addr, usr_wdata,
    output usr_gnt, usr_rvalid, usr_rdata
  );

endinterface

// File: rtl/scrub_bram.sv
// DEPTH x WID simple-dual-port block RAM, registered read-first output.
module scrub_bram
  import bram_ctrl_pkg::*;
#(
  parameter int WID   = WID_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic           clk,
  input  logic           we,
  input  logic [AW-1:0]  waddr,
  input  logic [WID-1:0] din,
  input  logic [AW-1:0]  raddr,
  output logic [WID-1:0] dout
);

  (* ram_style = "block" *) logic [WID-1:0] mem [DEPTH];
  logic [WID-1:0] rdata_q;

  // Write port and registered read; a same-address read sees the old word.
  // NOTE: no reset here -- a reset on the array or its output register
  // stops the tools mapping it onto a block RAM, and contents must survive reset anyway.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= din;
    end
    rdata_q <= mem[raddr];
  end

  assign dout = rdata_q;

endmodule

// File: rtl/bram_scrub_ctrl.sv
// Fill / verify sweep engine sharing one BRAM with a priority user port.
// The user wins every cycle except when the engine has stalled STALL_LIMIT
// cycles in a row, at which point the engine takes one forced slot.
module bram_scrub_ctrl
  import bram_ctrl_pkg::*;
#(
  parameter int WID         = WID_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int AW          = AW_DEF,
  parameter int STALL_LIMIT = STALL_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [WID-1:0]    pattern,
  output logic              busy,
  output logic              done,
  output logic [WID-1:0]    checksum,
  bram_scrub_ctrl_if.slave  usr,
  output logic [AW-1:0]     mem_raddr,
  output logic [AW-1:0]     mem_waddr,
  output logic [WID-1:0]    mem_din,
  output logic              mem_we,
  input  logic [WID-1:0]    mem_dout
);

  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_e         state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [SW-1:0]  stall_q, stall_d;
  logic [WID-1:0] checksum_q, checksum_d;
  logic [WID-1:0] pattern_q, pattern_d;
  logic           fv_q, fv_d;
  logic           rd_pend_q, rd_pend_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           rvalid_q, rvalid_d;

  logic eng_active;
  logic forced;
  logic usr_gnt;
  logic eng_own;

  // Arbitration: user first, except on the engine's forced slot.
  assign eng_active = (state_q == S_FILL) || (state_q == S_VERIFY);
  assign forced     = eng_active && (stall_q == SW'(STALL_LIMIT));
  assign usr_gnt    = usr.usr_req && !forced;
  assign eng_own    = eng_active && !usr_gnt;

  // Sweep sequencing, address walk, stall tracking and checksum accumulation.
  // NOTE: every variable gets its hold value first so no path leaves one
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    stall_d    = stall_q;
    checksum_d = checksum_q;
    pattern_d  = pattern_q;
    fv_d       = fv_q;
    rd_pend_d  = 1'b0;

    // Read data lands one cycle after issue, whoever owns the RAM now.
    if (rd_pend_q) begin
      checksum_d = checksum_q + mem_dout;
    end

    if (eng_active && usr_gnt) begin
      stall_d = stall_q + SW'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pattern_d  = pattern;
          checksum_d = '0;
          addr_d     = '0;
          stall_d    = '0;
          fv_d       = (mode == MODE_FILL_VERIFY);
          state_d    = mode_fills(mode) ? S_FILL : S_VERIFY;
        end
      end

      S_FILL: begin
        if (eng_own) begin
          stall_d = '0;
          if (addr_q == LAST_ADDR) begin
            addr_d  = '0;
            state_d = fv_q ? S_VERIFY : S_DONE;
          end else begin
            addr_d = addr_q + AW'(1);
          end
        end
      end

      S_VERIFY: begin
        if (eng_own) begin
          stall_d   = '0;
          rd_pend_d = 1'b1;
          if (addr_q == LAST_ADDR) begin
            addr_d  = '0;
            state_d = S_DRAIN;
          end else begin
            addr_d = addr_q + AW'(1);
          end
        end
      end

      // The final read's data is absorbed by the checksum this cycle.
      S_DRAIN: state_d = S_DONE;

      S_DONE:  state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    busy_d   = (state_d == S_FILL) || (state_d == S_VERIFY) || (state_d == S_DRAIN);
    done_d   = (state_d == S_DONE);
    rvalid_d = usr_gnt && !usr.usr_we;
  end

  // State and registered outputs; reset returns to idle mid-sweep.
  // NOTE: non-blocking assignments so every flop samples the pre-edge values
  // regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      stall_q    <= '0;
      checksum_q <= '0;
      pattern_q  <= '0;
      fv_q       <= 1'b0;
      rd_pend_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      stall_q    <= stall_d;
      checksum_q <= checksum_d;
      pattern_q  <= pattern_d;
      fv_q       <= fv_d;
      rd_pend_q  <= rd_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rvalid_q   <= rvalid_d;
    end
  end

  // RAM pin mux: the granted user drives everything, otherwise the engine.
  always_comb begin
    if (usr_gnt) begin
      mem_raddr = usr.usr_addr;
      mem_waddr = usr.usr_addr;
      mem_din   = usr.usr_wdata;
      mem_we    = usr.usr_we;
    end else begin
      mem_raddr = addr_q;
      mem_waddr = addr_q;
      mem_din   = pattern_q;
      mem_we    = eng_own && (state_q == S_FILL);
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign checksum       = checksum_q;
  assign usr.usr_gnt    = usr_gnt;
  assign usr.usr_rvalid = rvalid_q;
  assign usr.usr_rdata  = mem_dout;

endmodule

// File: tb/tb_bram_scrub_ctrl.sv
// Bench for bram_scrub_ctrl wired to scrub_bram; user reads are scored
// against a bench-side memory model.
module tb_bram_scrub_ctrl;
  import bram_ctrl_pkg::*;

  localparam int WID   = 36;
  localparam int AW    = 11;
  localparam int DEPTH = 2048;

  localparam logic [WID-1:0] PB = 36'h5_A5A5_A5A5;
  localparam logic [WID-1:0] PC = 36'hF_0000_000F;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [1:0]     mode;
  logic [WID-1:0] pattern;
  logic           busy, done;
  logic [WID-1:0] checksum;
  logic [AW-1:0]  mem_raddr, mem_waddr;
  logic [WID-1:0] mem_din, mem_dout;
  logic           mem_we;

  bram_scrub_ctrl_if #(.WID(WID), .AW(AW)) uif ();

  always #5 clk = ~clk;

  bram_scrub_ctrl #(.WID(WID), .DEPTH(DEPTH), .AW(AW), .STALL_LIMIT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .pattern   (pattern),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum),
    .usr       (uif.slave),
    .mem_raddr (mem_raddr),
    .mem_waddr (mem_waddr),
    .mem_din   (mem_din),
    .mem_we    (mem_we),
    .mem_dout  (mem_dout)
  );

  scrub_bram #(.WID(WID), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .din   (mem_din),
    .raddr (mem_raddr),
    .dout  (mem_dout)
  );

  int             checks = 0;
  int             errors = 0;
  logic [WID-1:0] model [DEPTH];
  logic [WID-1:0] sb_q [$];
  bit             free_run = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WID-1:0] model_sum();
    logic [WID-1:0] s = '0;
    for (int i = 0; i < DEPTH; i++) s = s + model[i];
    return s;
  endfunction

  // Read-return scoreboard: every rvalid must match the oldest expected word.
  initial begin
    logic [WID-1:0] exp;
    forever begin
      @(posedge clk);
      #2;
      if (uif.usr_rvalid === 1'b1) begin
        if (sb_q.size() > 0) begin
          exp = sb_q.pop_front();
          check("usr_rdata", uif.usr_rdata, exp);
        end else if (!free_run) begin
          check("rvalid_spurious", uif.usr_rvalid, 1'b0);
        end
      end
    end
  end

  // One user access; waits (bounded) for grant, updates model or scoreboard.
  task automatic usr_op(input bit w, input logic [AW-1:0] a, input logic [WID-1:0] d);
    int n = 0;
    @(negedge clk);
    uif.usr_req   = 1'b1;
    uif.usr_we    = w;
    uif.usr_addr  = a;
    uif.usr_wdata = d;
    #1;
    while (!uif.usr_gnt && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("usr_gnt", uif.usr_gnt, 1'b1);
    if (uif.usr_gnt) begin
      if (w) model[a] = d;
      else   sb_q.push_back(model[a]);
    end
    @(posedge clk);
    #1;
    if (!w) check("usr_rvalid_lat", uif.usr_rvalid, 1'b1);
    uif.usr_req = 1'b0;
    uif.usr_we  = 1'b0;
  endtask

  task automatic wait_sb();
    int n = 0;
    while (sb_q.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("sb_drain", sb_q.size(), 0);
  endtask

  // Launch a sweep and count cycles until done. cyc counts clocks from the
  // start pulse to the done cycle; busy_cnt counts busy cycles. With hold_req
  // the user request is held high and the grant must drop every 5th busy cycle.
  task automatic run_sweep(input logic [1:0] m, input logic [WID-1:0] p,
                           input int restart_at, input bit poke_done, input bit hold_req,
                           input int budget,
                           output int cyc, output int busy_cnt, output int gnt_err);
    logic exp_g;
    @(negedge clk);
    start    = 1'b1;
    mode     = m;
    pattern  = p;
    cyc      = 0;
    busy_cnt = 0;
    gnt_err  = 0;
    while (cyc < budget) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      #1;
      if (cyc == restart_at) begin
        start   = 1'b1;
        mode    = 2'd1;
        pattern = ~p;
      end
      if (busy) begin
        if (hold_req) begin
          exp_g = (busy_cnt % 5) != 4;
          if (uif.usr_gnt !== exp_g) gnt_err++;
        end
        busy_cnt++;
      end
      if (done) break;
    end
    check("done_seen", done, 1'b1);
    if (poke_done) begin
      start   = 1'b1;
      mode    = 2'd1;
      pattern = ~p;
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    check("done_one_cycle", done, 1'b0);
    check("idle_after_done", busy, 1'b0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int cyc, bc, ge;

    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    reset         = 1'b1;
    start         = 1'b0;
    mode          = 2'd0;
    pattern       = '0;
    uif.usr_req   = 1'b0;
    uif.usr_we    = 1'b0;
    uif.usr_addr  = '0;
    uif.usr_wdata = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_checksum", checksum, 36'h0);
    check("rst_rvalid", uif.usr_rvalid, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // FILL_VERIFY with pattern 1.
    run_sweep(2'd2, 36'h0_0000_0001, -1, 1'b0, 1'b0, 5000, cyc, bc, ge);
    for (int i = 0; i < DEPTH; i++) model[i] = 36'h1;
    check("fv_busy_cycles", bc, 4097);
    check("fv_done_cycle", cyc, 4098);
    check("fv_checksum", checksum, 36'h0_0000_0800);
    repeat (5) @(negedge clk);
    check("checksum_hold", checksum, 36'h0_0000_0800);

    // Preload word[i] = i through the user port, then VERIFY.
    for (int i = 0; i < DEPTH; i++) usr_op(1'b1, AW'(i), WID'(i));
    run_sweep(2'd0, '0, -1, 1'b0, 1'b0, 3000, cyc, bc, ge);
    check("v_done_cycle", cyc, 2050);
    check("v_busy_cycles", bc, 2049);
    check("v_checksum", checksum, 36'h0_001F_FC00);

    // User write then read at the top address, plus a preloaded word.
    usr_op(1'b1, 11'h7FF, 36'hA_BCDE_F012);
    usr_op(1'b0, 11'h7FF, '0);
    usr_op(1'b0, 11'd5, '0);
    wait_sb();

    // FILL with the user request held high: forced slot every 5th cycle.
    free_run      = 1'b1;
    uif.usr_addr  = 11'h010;
    uif.usr_we    = 1'b0;
    uif.usr_req   = 1'b1;
    run_sweep(2'd1, PB, -1, 1'b0, 1'b1, 11000, cyc, bc, ge);
    uif.usr_req = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = PB;
    check("hold_gnt_pattern_errs", ge, 0);
    check("hold_fill_cycles", bc, 5 * 2048);
    repeat (3) @(negedge clk);
    free_run = 1'b0;
    sb_q.delete();

    // Mode 3 acts as VERIFY; restart mid-sweep and start during DONE ignored.
    run_sweep(2'd3, '0, 700, 1'b1, 1'b0, 3000, cyc, bc, ge);
    check("m3_done_cycle", cyc, 2050);
    check("m3_checksum", checksum, model_sum());
    repeat (4) @(negedge clk);
    check("m3_no_second_done", busy, 1'b0);
    usr_op(1'b0, 11'd0, '0);
    usr_op(1'b0, 11'h7FF, '0);
    wait_sb();

    // Reset during FILL with the address counter at 100.
    @(negedge clk);
    start   = 1'b1;
    mode    = 2'd1;
    pattern = PC;
    for (int k = 1; k <= 101; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_checksum", checksum, 36'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) model[i] = PC;

    run_sweep(2'd0, '0, -1, 1'b0, 1'b0, 3000, cyc, bc, ge);
    check("post_rst_done_cycle", cyc, 2050);
    check("post_rst_checksum", checksum, model_sum());
    usr_op(1'b0, 11'd99, '0);
    usr_op(1'b0, 11'd100, '0);
    usr_op(1'b0, 11'd0, '0);
    usr_op(1'b0, 11'h7FF, '0);
    wait_sb();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
